// File: rtl/cve2_csr_access_stage.sv
// Sequences one CSR access (read/write/set/clear) into a single CSR register and returns the old value.
// Latency: write strobe in the cycle after acceptance, response valid one cycle later; one access per 3+ cycles.
// Backpressure: req_ready_o is high only in IDLE; RESP holds with stable outputs until rsp_ready_i.
module cve2_csr_access_stage #(
    parameter int unsigned      Width     = 32,
    parameter logic [Width-1:0] WriteMask = {Width{1'b1}},
    parameter bit               ReadOnly  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Width-1:0] csr_rdata_i,
    input  logic             csr_rd_error_i,
    output logic [Width-1:0] csr_wr_data_o,
    output logic             csr_wr_en_o,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_error_o,
    output logic [7:0]       err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [Width-1:0] operand_q;
    logic [Width-1:0] rsp_rdata_q;
    logic             rsp_error_q;
    logic [7:0]       err_cnt_q;

    logic [Width-1:0] raw_val;
    logic             write_kind;
    logic             access_err;
    logic             in_exec;

    // Set/clear with a zero operand cannot change anything, so it is treated as a pure read.
    always_comb begin
        raw_val = csr_rdata_i;
        case (op_q)
            OpRead:  raw_val = csr_rdata_i;
            OpWrite: raw_val = operand_q;
            OpSet:   raw_val = csr_rdata_i | operand_q;
            OpClear: raw_val = csr_rdata_i & ~operand_q;
            default: raw_val = csr_rdata_i;
        endcase
        write_kind = (op_q == OpWrite) ||
                     (((op_q == OpSet) || (op_q == OpClear)) && (operand_q != '0));
        access_err = csr_rd_error_i || (write_kind && ReadOnly);
        in_exec    = (state_q == EXEC);
    end

    assign csr_wr_en_o   = in_exec && write_kind && !access_err;
    assign csr_wr_data_o = in_exec ? ((csr_rdata_i & ~WriteMask) | (raw_val & WriteMask)) : '0;
    assign req_ready_o   = (state_q == IDLE);
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_error_o   = rsp_error_q;
    assign err_cnt_o     = err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            operand_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q      <= req_op_i;
                        operand_q <= req_wdata_i;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_rdata_q <= csr_rdata_i;
                    rsp_error_q <= access_err;
                    if (access_err && (err_cnt_q != 8'hFF)) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cve2_csr_access_stage.sv
// Drives three stage variants (default, half write mask, read-only) in lockstep against a transaction-level model.
module tb_cve2_csr_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_wdata = 32'h0;
    logic        rd_err = 1'b0;
    logic        rsp_ready = 1'b0;

    logic        req_ready [3];
    logic [31:0] wr_data   [3];
    logic        wr_en     [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_error [3];
    logic [7:0]  err_cnt   [3];

    logic [31:0] csr_reg [3];
    logic        load_en = 1'b0;
    logic [31:0] load_val = 32'h0;

    // Expected register contents and error counts
    logic [31:0] reg_m [3];
    int          cnt_m [3];

    logic [31:0] cap_wd  [3];
    logic        cap_we  [3];
    logic [31:0] cap_rd  [3];
    logic        cap_err [3];
    logic [7:0]  cap_cnt [3];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    cve2_csr_access_stage u0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
        .req_op_i(req_op), .req_wdata_i(req_wdata), .csr_rdata_i(csr_reg[0]),
        .csr_rd_error_i(rd_err), .csr_wr_data_o(wr_data[0]), .csr_wr_en_o(wr_en[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[0]),
        .rsp_error_o(rsp_error[0]), .err_cnt_o(err_cnt[0])
    );

    cve2_csr_access_stage #(.WriteMask(32'h0000_FFFF)) u1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
        .req_op_i(req_op), .req_wdata_i(req_wdata), .csr_rdata_i(csr_reg[1]),
        .csr_rd_error_i(rd_err), .csr_wr_data_o(wr_data[1]), .csr_wr_en_o(wr_en[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[1]),
        .rsp_error_o(rsp_error[1]), .err_cnt_o(err_cnt[1])
    );

    cve2_csr_access_stage #(.ReadOnly(1'b1)) u2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready[2]),
        .req_op_i(req_op), .req_wdata_i(req_wdata), .csr_rdata_i(csr_reg[2]),
        .csr_rd_error_i(rd_err), .csr_wr_data_o(wr_data[2]), .csr_wr_en_o(wr_en[2]),
        .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[2]),
        .rsp_error_o(rsp_error[2]), .err_cnt_o(err_cnt[2])
    );

    // Stand-in for the CSR storage register behind each stage
    always @(posedge clk_i) begin
        for (int d = 0; d < 3; d++) begin
            if (load_en) csr_reg[d] <= load_val;
            else if (wr_en[d]) csr_reg[d] <= wr_data[d];
        end
    end

    function automatic logic [31:0] mask_of(input int d);
        return (d == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", name, d, act, exp, $time);
    endtask

    task automatic chk_reset_outputs();
        for (int d = 0; d < 3; d++) begin
            chk("rst_req_ready", d, {31'b0, req_ready[d]}, 32'd1);
            chk("rst_wr_en", d, {31'b0, wr_en[d]}, 32'd0);
            chk("rst_wr_data", d, wr_data[d], 32'd0);
            chk("rst_rsp_valid", d, {31'b0, rsp_valid[d]}, 32'd0);
            chk("rst_rsp_rdata", d, rsp_rdata[d], 32'd0);
            chk("rst_rsp_error", d, {31'b0, rsp_error[d]}, 32'd0);
            chk("rst_err_cnt", d, {24'b0, err_cnt[d]}, 32'd0);
        end
    endtask

    task automatic preload(input logic [31:0] v);
        @(negedge clk_i);
        req_valid = 1'b0;
        load_en = 1'b1;
        load_val = v;
        @(negedge clk_i);
        load_en = 1'b0;
        for (int d = 0; d < 3; d++) reg_m[d] = v;
    endtask

    task automatic access(input logic [1:0] op, input logic [31:0] wd, input logic rderr,
                          input int delay, input bit rst_in_exec);
        logic [31:0] old_v [3];
        bit          exp_err [3];
        logic [31:0] raw, nv;
        bit          wk, we;
        // IDLE: offer the request
        @(negedge clk_i);
        req_valid = 1'b1; req_op = op; req_wdata = wd;
        rd_err = 1'($urandom); rsp_ready = 1'($urandom);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("idle_req_ready", d, {31'b0, req_ready[d]}, 32'd1);
            chk("idle_rsp_valid", d, {31'b0, rsp_valid[d]}, 32'd0);
            chk("idle_wr_en", d, {31'b0, wr_en[d]}, 32'd0);
            chk("idle_wr_data", d, wr_data[d], 32'd0);
        end
        // EXEC: scramble request inputs, they must be ignored now
        @(negedge clk_i);
        req_valid = 1'($urandom); req_op = 2'($urandom); req_wdata = $urandom;
        rd_err = rderr; rsp_ready = 1'($urandom);
        #1;
        for (int d = 0; d < 3; d++) begin
            old_v[d] = reg_m[d];
            chk("exec_reg_content", d, csr_reg[d], reg_m[d]);
            case (op)
                2'b01:   raw = wd;
                2'b10:   raw = old_v[d] | wd;
                2'b11:   raw = old_v[d] & ~wd;
                default: raw = old_v[d];
            endcase
            nv = (old_v[d] & ~mask_of(d)) | (raw & mask_of(d));
            wk = (op == 2'b01) || (op[1] && wd != 32'h0);
            exp_err[d] = rderr || (wk && d == 2);
            we = wk && !exp_err[d];
            cap_wd[d] = wr_data[d];
            cap_we[d] = wr_en[d];
            chk("exec_req_ready", d, {31'b0, req_ready[d]}, 32'd0);
            chk("exec_wr_en", d, {31'b0, wr_en[d]}, {31'b0, we});
            if (we) chk("exec_wr_data", d, wr_data[d], nv);
            if (!rst_in_exec) begin
                if (we) reg_m[d] = nv;
                if (exp_err[d] && cnt_m[d] < 255) cnt_m[d]++;
            end
        end
        if (rst_in_exec) begin
            rst_ni = 1'b0;
            #1;
            chk_reset_outputs();
            for (int d = 0; d < 3; d++) cnt_m[d] = 0;
            @(negedge clk_i);
            for (int d = 0; d < 3; d++) chk("rst_no_write", d, csr_reg[d], reg_m[d]);
            chk_reset_outputs();
            req_valid = 1'b0;
            rst_ni = 1'b1;
            return;
        end
        // RESP: outputs must hold while stalled, no new request may be taken
        for (int k = 0; k <= delay; k++) begin
            @(negedge clk_i);
            req_valid = 1'($urandom); req_op = 2'($urandom); req_wdata = $urandom;
            rd_err = 1'($urandom); rsp_ready = (k == delay);
            #1;
            for (int d = 0; d < 3; d++) begin
                chk("resp_valid", d, {31'b0, rsp_valid[d]}, 32'd1);
                chk("resp_req_ready", d, {31'b0, req_ready[d]}, 32'd0);
                chk("resp_rdata", d, rsp_rdata[d], old_v[d]);
                chk("resp_error", d, {31'b0, rsp_error[d]}, {31'b0, exp_err[d]});
                chk("resp_err_cnt", d, {24'b0, err_cnt[d]}, cnt_m[d]);
                chk("resp_wr_en", d, {31'b0, wr_en[d]}, 32'd0);
                chk("resp_wr_data", d, wr_data[d], 32'd0);
                chk("resp_reg_content", d, csr_reg[d], reg_m[d]);
                cap_rd[d] = rsp_rdata[d];
                cap_err[d] = rsp_error[d];
                cap_cnt[d] = err_cnt[d];
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            reg_m[d] = 32'h0;
            cnt_m[d] = 0;
        end
        #2;
        chk_reset_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Plain write, with the read-only variant rejecting it
        preload(32'h0000_00F0);
        access(2'b01, 32'h1234_5678, 1'b0, 0, 1'b0);
        chk("lit_write_data", 0, cap_wd[0], 32'h1234_5678);
        chk("lit_write_en", 0, {31'b0, cap_we[0]}, 32'd1);
        chk("lit_write_old", 0, cap_rd[0], 32'h0000_00F0);
        chk("lit_write_err", 0, {31'b0, cap_err[0]}, 32'd0);
        chk("lit_ro_err", 2, {31'b0, cap_err[2]}, 32'd1);
        chk("lit_ro_cnt", 2, {24'b0, cap_cnt[2]}, 32'd1);

        // Set then clear
        preload(32'h0000_00F0);
        access(2'b10, 32'h0000_000F, 1'b0, 0, 1'b0);
        chk("lit_set_data", 0, cap_wd[0], 32'h0000_00FF);
        chk("lit_set_old", 0, cap_rd[0], 32'h0000_00F0);
        access(2'b11, 32'h0000_00C0, 1'b0, 1, 1'b0);
        chk("lit_clr_data", 0, cap_wd[0], 32'h0000_003F);
        chk("lit_clr_old", 0, cap_rd[0], 32'h0000_00FF);

        // Zero-operand set and plain read never write or fault
        access(2'b10, 32'h0, 1'b0, 0, 1'b0);
        chk("lit_set0_we", 0, {31'b0, cap_we[0]}, 32'd0);
        chk("lit_set0_ro_err", 2, {31'b0, cap_err[2]}, 32'd0);
        access(2'b00, $urandom, 1'b0, 0, 1'b0);
        chk("lit_read_we", 0, {31'b0, cap_we[0]}, 32'd0);
        chk("lit_read_old", 0, cap_rd[0], 32'h0000_003F);

        // Masked write keeps upper half
        preload(32'hAAAA_0000);
        access(2'b01, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        chk("lit_mask_data", 1, cap_wd[1], 32'hAAAA_FFFF);

        // Shadow mismatch, then long response stall, then reset during EXEC
        access(2'b01, 32'h5, 1'b1, 0, 1'b0);
        chk("lit_rderr_we", 0, {31'b0, cap_we[0]}, 32'd0);
        chk("lit_rderr_err", 0, {31'b0, cap_err[0]}, 32'd1);
        access(2'b01, 32'h0BAD_F00D, 1'b0, 5, 1'b0);
        access(2'b01, 32'hDEAD_BEEF, 1'b0, 0, 1'b1);

        // Counter saturation
        for (int i = 0; i < 300; i++) access(2'($urandom), $urandom, 1'b1, 0, 1'b0);
        chk("lit_sat_cnt", 0, {24'b0, cap_cnt[0]}, 32'd255);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            logic [31:0] w;
            if ($urandom_range(0, 15) == 0) preload($urandom);
            w = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            access(2'($urandom), w, ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
